// File: rtl/attitude_pkg.sv
// Shared constants and state encodings for the attitude telemetry receiver.
package attitude_pkg;

  localparam logic [7:0] START_BYTE = 8'hAA;
  localparam logic [7:0] END_BYTE   = 8'h55;
  localparam int         FRAME_LEN  = 6;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  typedef enum logic [2:0] {
    P_WAIT_START,
    P_ROLL_L,
    P_ROLL_H,
    P_PITCH_L,
    P_PITCH_H,
    P_WAIT_END
  } parse_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchronizer, mid-bit sampling, stop-bit check.
module uart_rx_byte
  import attitude_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx_serial,
  output logic       o_rx_dv,
  output logic       o_rx_err,
  output logic [7:0] o_rx_byte
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);

  logic             rx_meta_q, rx_sync_q;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             dv_q, dv_d;
  logic             err_q, err_d;

  // o_rx_dv / o_rx_err are single-cycle strobes, never together; o_rx_byte is
  // valid in the rx_dv cycle and holds until the next byte starts shifting in.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    dv_d    = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!rx_sync_q) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_BIT) begin
          cnt_d   = '0;
          state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_BIT) begin
          cnt_d   = '0;
          shreg_d = {rx_sync_q, shreg_q[7:1]};
          if (bit_q == 3'd7) state_d = RX_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_BIT) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (rx_sync_q) dv_d  = 1'b1;
          else           err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      dv_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      rx_meta_q <= i_rx_serial;
      rx_sync_q <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      dv_q      <= dv_d;
      err_q     <= err_d;
    end
  end

  assign o_rx_dv   = dv_q;
  assign o_rx_err  = err_q;
  assign o_rx_byte = shreg_q;

endmodule

// File: rtl/attitude_uart_rx.sv
// Attitude telemetry receiver: parses AA rollL rollH pitchL pitchH 55 frames
// from the UART byte stream and publishes roll/pitch atomically.
module attitude_uart_rx
  import attitude_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 217,
  parameter int         TIMEOUT_BITS = 20,
  parameter logic [7:0] START_BYTE   = attitude_pkg::START_BYTE,
  parameter logic [7:0] END_BYTE     = attitude_pkg::END_BYTE
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_rx_serial,
  output logic [15:0] o_roll,
  output logic [15:0] o_pitch,
  output logic        o_valid,
  output logic        o_frame_err,
  output logic        o_timeout_err,
  output logic [7:0]  o_pkt_count
);

  localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TO_W     = $clog2(TO_LIMIT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_LIMIT - 1);

  logic       rx_dv, rx_err;
  logic [7:0] rx_byte;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_rx_serial(i_rx_serial),
    .o_rx_dv    (rx_dv),
    .o_rx_err   (rx_err),
    .o_rx_byte  (rx_byte)
  );

  parse_state_e    state_q, state_d;
  logic [15:0]     roll_sh_q, roll_sh_d;
  logic [15:0]     pitch_sh_q, pitch_sh_d;
  logic [15:0]     roll_q, roll_d;
  logic [15:0]     pitch_q, pitch_d;
  logic [7:0]      pkt_q, pkt_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            tout_q, tout_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  always_comb begin
    state_d    = state_q;
    roll_sh_d  = roll_sh_q;
    pitch_sh_d = pitch_sh_q;
    roll_d     = roll_q;
    pitch_d    = pitch_q;
    pkt_d      = pkt_q;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;
    tout_d     = 1'b0;
    to_cnt_d   = to_cnt_q;
    // A received byte takes priority over a timeout expiring in the same clock.
    if (rx_dv) begin
      to_cnt_d = '0;
      case (state_q)
        P_WAIT_START: if (rx_byte == START_BYTE) state_d = P_ROLL_L;
        P_ROLL_L:  begin roll_sh_d[7:0]   = rx_byte; state_d = P_ROLL_H;   end
        P_ROLL_H:  begin roll_sh_d[15:8]  = rx_byte; state_d = P_PITCH_L;  end
        P_PITCH_L: begin pitch_sh_d[7:0]  = rx_byte; state_d = P_PITCH_H;  end
        P_PITCH_H: begin pitch_sh_d[15:8] = rx_byte; state_d = P_WAIT_END; end
        P_WAIT_END: begin
          if (rx_byte == END_BYTE) begin
            roll_d  = roll_sh_q;
            pitch_d = pitch_sh_q;
            valid_d = 1'b1;
            pkt_d   = pkt_q + 8'd1;
            state_d = P_WAIT_START;
          end else begin
            ferr_d  = 1'b1;
            state_d = (rx_byte == START_BYTE) ? P_ROLL_L : P_WAIT_START;
          end
        end
        default: state_d = P_WAIT_START;
      endcase
    end else if (rx_err) begin
      to_cnt_d = '0;
      if (state_q != P_WAIT_START) begin
        ferr_d  = 1'b1;
        state_d = P_WAIT_START;
      end
    end else if (state_q == P_WAIT_START) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TO_LAST) begin
      tout_d   = 1'b1;
      state_d  = P_WAIT_START;
      to_cnt_d = '0;
    end else begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= P_WAIT_START;
      roll_sh_q  <= '0;
      pitch_sh_q <= '0;
      roll_q     <= '0;
      pitch_q    <= '0;
      pkt_q      <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      tout_q     <= 1'b0;
      to_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      roll_sh_q  <= roll_sh_d;
      pitch_sh_q <= pitch_sh_d;
      roll_q     <= roll_d;
      pitch_q    <= pitch_d;
      pkt_q      <= pkt_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      tout_q     <= tout_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  assign o_roll        = roll_q;
  assign o_pitch       = pitch_q;
  assign o_valid       = valid_q;
  assign o_frame_err   = ferr_q;
  assign o_timeout_err = tout_q;
  assign o_pkt_count   = pkt_q;

endmodule

// File: tb/tb_attitude_uart_rx.sv
// Scoreboard bench for attitude_uart_rx: frame-buffer reference model feeds an
// expected-event queue, a negedge monitor pops and compares every output pulse.
module tb_attitude_uart_rx;

  localparam int CPB     = 16;
  localparam int TO_BITS = 20;
  localparam logic [1:0] EV_VALID = 2'd1;
  localparam logic [1:0] EV_FERR  = 2'd2;
  localparam logic [1:0] EV_TOUT  = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic [15:0] roll, pitch;
  logic        valid, ferr, terr;
  logic [7:0]  pkt;

  attitude_uart_rx #(
    .CLKS_PER_BIT(CPB),
    .TIMEOUT_BITS(TO_BITS),
    .START_BYTE  (8'hAA),
    .END_BYTE    (8'h55)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_rx_serial  (rx),
    .o_roll       (roll),
    .o_pitch      (pitch),
    .o_valid      (valid),
    .o_frame_err  (ferr),
    .o_timeout_err(terr),
    .o_pkt_count  (pkt)
  );

  // clock / reset
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [41:0] exp_q[$];      // {kind, pkt, pitch, roll}
  logic [7:0]  frame_buf[$];  // bytes of the frame in progress, header first
  logic [15:0] m_roll = '0;
  logic [15:0] m_pitch = '0;
  logic [7:0]  m_pkt = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [41:0] ev(input logic [1:0] kind);
    return {kind, m_pkt, m_pitch, m_roll};
  endfunction

  // reference model: one call per byte put on the line
  task automatic model_byte(input logic [7:0] b, input bit stop_ok);
    if (!stop_ok) begin
      if (frame_buf.size() > 0) begin
        exp_q.push_back(ev(EV_FERR));
        frame_buf.delete();
      end
      return;
    end
    if (frame_buf.size() == 0) begin
      if (b == 8'hAA) frame_buf.push_back(b);
      return;
    end
    frame_buf.push_back(b);
    if (frame_buf.size() == 6) begin
      if (b == 8'h55) begin
        m_roll  = {frame_buf[2], frame_buf[1]};
        m_pitch = {frame_buf[4], frame_buf[3]};
        m_pkt   = m_pkt + 8'd1;
        exp_q.push_back(ev(EV_VALID));
        frame_buf.delete();
      end else begin
        exp_q.push_back(ev(EV_FERR));
        frame_buf.delete();
        if (b == 8'hAA) frame_buf.push_back(b);
      end
    end
  endtask

  // driver tasks
  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    model_byte(b, stop_ok);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_ok;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    if (!stop_ok) repeat (12 * CPB) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    if (n >= TO_BITS + 2 && frame_buf.size() > 0) begin
      exp_q.push_back(ev(EV_TOUT));
      frame_buf.delete();
    end
    rx = 1'b1;
    repeat (n * CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [15:0] r, input logic [15:0] p, input logic [7:0] trailer);
    logic [7:0] bytes [6];
    bytes = '{8'hAA, r[7:0], r[15:8], p[7:0], p[15:8], trailer};
    for (int i = 0; i < 6; i++) begin
      send_byte(bytes[i], 1'b1);
      if (i < 5) idle_bits($urandom_range(0, 3));
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 40 * CPB) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_roll"}, roll, m_roll);
    check({name, "_pitch"}, pitch, m_pitch);
    check({name, "_pkt"}, pkt, m_pkt);
    check({name, "_pulses"}, {valid, ferr, terr}, 3'b000);
  endtask

  // monitor / scoreboard
  logic [41:0] mon_e;
  logic [1:0]  mon_kind;
  int          mon_hot;
  always @(negedge clk) begin
    if (rst_n && (valid || ferr || terr)) begin
      mon_hot  = int'(valid) + int'(ferr) + int'(terr);
      mon_kind = valid ? EV_VALID : (ferr ? EV_FERR : EV_TOUT);
      check("single_pulse", 64'(mon_hot), 64'd1);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got kind %0d expected no pulse", mon_kind);
      end else begin
        mon_e = exp_q.pop_front();
        check("event_kind", mon_kind, mon_e[41:40]);
        check("roll", roll, mon_e[15:0]);
        check("pitch", pitch, mon_e[31:16]);
        check("pkt_count", pkt, mon_e[39:32]);
      end
    end
  end

  initial begin
    repeat (200000) @(posedge clk);
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] partial;
    int         kind;
    partial = 8'h5A;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("reset");

    send_frame(16'h1234, 16'h5678, 8'h55);
    drain("f1_drain");
    check("f1_roll", roll, 16'h1234);
    check("f1_pitch", pitch, 16'h5678);
    check("f1_pkt", pkt, 8'd1);

    send_byte(8'h00, 1'b1);
    idle_bits(1);
    send_byte(8'hFF, 1'b1);
    idle_bits(1);
    send_frame(16'hAA55, 16'h55AA, 8'h55);
    drain("f2_drain");
    check("f2_roll", roll, 16'hAA55);
    check("f2_pitch", pitch, 16'h55AA);
    check("f2_pkt", pkt, 8'd2);

    send_frame(16'h0201, 16'h0403, 8'h00);
    drain("bad_trailer_drain");
    check("bad_trailer_roll", roll, 16'hAA55);

    send_byte(8'hAA, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    idle_bits(TO_BITS + 2);
    drain("timeout_drain");
    send_frame(16'h0010, 16'h0020, 8'h55);
    drain("after_timeout_drain");
    check("after_timeout_roll", roll, 16'h0010);
    check("after_timeout_pitch", pitch, 16'h0020);

    rx = 1'b0;
    repeat (CPB / 2 - 4) @(negedge clk);
    rx = 1'b1;
    idle_bits(4);
    check_idle_outputs("glitch");

    send_byte(8'hAA, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b0);
    drain("bad_stop_drain");
    send_frame(16'hBEEF, 16'h8001, 8'h55);
    drain("after_bad_stop_drain");
    check("after_bad_stop_pkt", pkt, 8'd4);

    send_byte(8'hAA, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = partial[i];
      repeat (CPB) @(negedge clk);
    end
    rst_n = 1'b0;
    check("queue_before_reset", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    frame_buf.delete();
    m_roll  = '0;
    m_pitch = '0;
    m_pkt   = '0;
    rx = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("mid_reset");
    send_frame(16'h4321, 16'h8765, 8'h55);
    drain("after_reset_drain");
    check("after_reset_pkt", pkt, 8'd1);
    check("after_reset_roll", roll, 16'h4321);

    for (int it = 0; it < 30; it++) begin
      kind = $urandom_range(0, 4);
      case (kind)
        0, 1: send_frame(16'($urandom), 16'($urandom), 8'h55);
        2: send_frame(16'($urandom), 16'($urandom), 8'($urandom));
        3: begin
          send_byte(8'hAA, 1'b1);
          for (int k = $urandom_range(0, 4); k > 0; k--) send_byte(8'($urandom), 1'b1);
          idle_bits(TO_BITS + 2);
        end
        default: begin
          send_byte(8'hAA, 1'b1);
          send_byte(8'($urandom), 1'b1);
          send_byte(8'($urandom), 1'b0);
        end
      endcase
      idle_bits(2);
    end

    drain("final_drain");
    check_idle_outputs("final");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/attitude_uart_rx.md
Name: attitude_uart_rx

Overview:
- Ground-side counterpart of the board's attitude telemetry transmitter.
- Deserializes an 8N1 UART stream and parses 6-byte frames: 0xAA, roll LSB, roll MSB, pitch LSB, pitch MSB, 0x55.
- Presents the latest valid roll/pitch raw Euler words (BNO055 format, 16 LSB/deg, two's complement) with a one-cycle update strobe and error pulses.
- Sits behind the board RX pin, feeding downstream display/attitude logic.

Parameters:
- CLKS_PER_BIT, 217, clocks per UART bit (25 MHz / 115200).
- TIMEOUT_BITS, 20, inter-byte silence (in bit times) that aborts a partial frame.
- START_BYTE, 8'hAA, frame header.
- END_BYTE, 8'h55, frame trailer.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_rx_serial  in  1  UART line, idle high, asynchronous to i_clk
- o_roll  out  16  last valid roll word {MSB,LSB}
- o_pitch  out  16  last valid pitch word {MSB,LSB}
- o_valid  out  1  one-cycle pulse when o_roll/o_pitch update
- o_frame_err  out  1  one-cycle pulse: bad trailer or UART stop-bit error inside a frame
- o_timeout_err  out  1  one-cycle pulse: partial frame aborted by silence
- o_pkt_count  out  8  count of valid frames, wraps 255->0

Behaviour:
- Reset, asynchronous on i_rst_n low:
  - o_roll, o_pitch, o_pkt_count = 0; all pulses = 0.
  - Synchronizer flops = 1 (idle). Byte engine in IDLE. Parser in WAIT_START. Timeout counter = 0.
  - Reset mid-byte or mid-frame discards all partial data.
- Input sync: 2-flop synchronizer on i_rx_serial. All sampling uses the synchronized bit.
- Byte engine states: IDLE, START, DATA, STOP.
  - IDLE: falling to 0 -> START, bit counter cleared.
  - START: at CLKS_PER_BIT/2 (integer divide) recheck line. If 0 -> DATA; if 1 -> glitch, back to IDLE with no strobe.
  - DATA: sample every CLKS_PER_BIT clocks, 8 bits, LSB first.
  - STOP: sample after CLKS_PER_BIT. If 1 -> internal rx_dv pulse with rx_byte. If 0 -> internal rx_err pulse and byte discarded. Either way -> IDLE.
  - After STOP, IDLE accepts the next start edge immediately (no wait for the full stop bit).
- Parser states: WAIT_START, ROLL_L, ROLL_H, PITCH_L, PITCH_H, WAIT_END. Each advances on rx_dv.
  - WAIT_START: START_BYTE -> ROLL_L; any other byte is ignored.
  - Payload states capture the byte into shadow registers. Payload bytes equal to 0xAA or 0x55 are plain data.
  - WAIT_END, byte == END_BYTE:
    - Copy shadows to o_roll/o_pitch together (never partially updated).
    - Pulse o_valid; increment o_pkt_count.
    - Go to WAIT_START.
  - WAIT_END, any other byte:
    - Pulse o_frame_err; outputs unchanged.
    - If that byte == START_BYTE -> ROLL_L (resync), else -> WAIT_START.
  - rx_err in any state other than WAIT_START: pulse o_frame_err, go to WAIT_START. In WAIT_START: silently ignored.
- Latency: o_valid and the output update are registered exactly 1 clock after the rx_dv of the trailer byte. The error pulses have the same 1-clock latency.
- Timeout:
  - Counter clears on every rx_dv/rx_err, and is held at 0 in WAIT_START.
  - Otherwise it increments each clock. Reaching TIMEOUT_BITS*CLKS_PER_BIT: pulse o_timeout_err, parser -> WAIT_START, counter clears.
  - If rx_dv and timeout expiry fall in the same clock, rx_dv wins: the byte is processed, no timeout pulse.
- At most one of o_valid / o_frame_err / o_timeout_err is high in any cycle.
- Arithmetic: counters are unsigned. The bit-clock counter must be wide enough for CLKS_PER_BIT-1. The timeout counter must be wide enough for TIMEOUT_BITS*CLKS_PER_BIT. Outputs are raw words; no shifting or sign handling inside the block.

Decomposition:
- Shared package attitude_pkg holds:
  - START_BYTE/END_BYTE constants.
  - Frame length 6.
  - Parser state encoding and byte-engine state encoding.
- One natural sub-module: uart_rx_byte (synchronizer + byte engine, outputs rx_dv, rx_err, rx_byte).
- attitude_uart_rx instantiates it and holds the parser, shadows and timeout.

Test Plan:
- Frame AA 34 12 78 56 55 -> o_roll=16'h1234, o_pitch=16'h5678, o_valid pulses once 1 clk after trailer rx_dv, o_pkt_count=1.
- Noise 00 FF then frame AA 55 AA AA 55 55 -> o_roll=16'hAA55, o_pitch=16'h55AA, single o_valid.
- Frame AA 01 02 03 04 00 -> o_frame_err pulse, o_roll/o_pitch keep prior values, o_valid stays 0.
- Send AA 01 02, then idle 20 bit times -> o_timeout_err pulse. Next full frame AA 10 00 20 00 55 -> o_roll=16'h0010, o_pitch=16'h0020.
- Start-bit glitch shorter than CLKS_PER_BIT/2 -> no byte, no pulses. Byte with stop bit 0 during ROLL_H -> o_frame_err, parser returns to WAIT_START.
- Assert i_rst_n low mid-PITCH_L, release, send full frame -> outputs 0 after reset, then correct values; o_pkt_count=1.
